// File: rtl/fyp_udp_pkt_gen_if.sv
// Header and payload bus between fyp_udp_pkt_gen and udp_checksum_gen.
//   hdr_valid/hdr_ready     : header handshake
//   udp_src/udp_dst/ip_dst  : fixed header fields
//   ip_id                   : IP identification of the current packet
//   tdata/tvalid/tready/tlast/tuser : 8-bit AXI-Stream payload
// master modport = generator side, slave modport = checksum side.
interface fyp_udp_pkt_gen_if;
    localparam int unsigned PORT_W = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ID_W   = 16;
    localparam int unsigned DATA_W = 8;

    logic              hdr_valid;
    logic              hdr_ready;
    logic [PORT_W-1:0] udp_src;
    logic [PORT_W-1:0] udp_dst;
    logic [ADDR_W-1:0] ip_dst;
    logic [ID_W-1:0]   ip_id;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (
        output hdr_valid, udp_src, udp_dst, ip_dst, ip_id,
        output tdata, tvalid, tlast, tuser,
        input  hdr_ready, tready
    );

    modport slave (
        input  hdr_valid, udp_src, udp_dst, ip_dst, ip_id,
        input  tdata, tvalid, tlast, tuser,
        output hdr_ready, tready
    );
endinterface

// File: rtl/fyp_udp_pkt_gen.sv
// Runtime-configurable UDP packet source feeding udp_checksum_gen.
// Generates bursts of cfg_pkt_count packets (0 = continuous) with a
// programmable payload length, pattern (constant / incrementing / PRBS-7)
// and inter-packet gap. Each packet carries an incrementing IP id.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, stop       : 1-cycle control pulses
//   cfg_payload_len   : payload bytes per packet (0 treated as 1)
//   cfg_mode          : 0/3 constant, 1 incrementing, 2 PRBS-7
//   cfg_pkt_count     : packets per burst, 0 = continuous
//   cfg_gap           : idle cycles between last beat and next header
//   bus               : header + payload bus (master modport)
//   pkts_sent         : packets completed since the last start
//   busy              : high whenever not idle
// Optional macro FYP_PKT_SEQ_EN: payload bytes 0..3 carry pkts_sent
// (big-endian) and the pattern starts at byte 4.
module fyp_udp_pkt_gen #(
    parameter logic [15:0]  UDP_SRC    = 16'h1111,
    parameter logic [15:0]  UDP_DST    = 16'h2222,
    parameter logic [31:0]  IP_DST     = 32'hc0a80105,
    parameter logic [7:0]   CONST_BYTE = 8'h11,
    parameter logic [6:0]   PRBS_SEED  = 7'h7F,
    parameter int unsigned  CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [15:0]          cfg_payload_len,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_WIDTH-1:0] cfg_pkt_count,
    input  logic [15:0]          cfg_gap,
    fyp_udp_pkt_gen_if.master    bus,
    output logic [CNT_WIDTH-1:0] pkts_sent,
    output logic                 busy
);
    localparam int unsigned LEN_W = 16;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_GAP} state_t;

    state_t               r_state, w_state;
    logic                 r_hdr_valid, w_hdr_valid;
    logic                 r_tvalid, w_tvalid;
    logic                 r_tlast, w_tlast;
    logic [7:0]           r_tdata, w_tdata;
    logic [15:0]          r_ip_id, w_ip_id;
    logic [CNT_WIDTH-1:0] r_pkts, w_pkts, w_pkts_inc;
    logic                 r_busy, w_busy;
    logic [LEN_W-1:0]     r_idx, w_idx;
    logic [7:0]           r_k, w_k;
    logic [15:0]          r_gap_cnt, w_gap_cnt;
    logic [6:0]           r_prbs, w_prbs, w_prbs_step;
    logic                 r_stop_pend, w_stop_pend;
    logic                 w_load, w_pat_beat;
    logic [7:0]           w_pat;

    // Burst configuration, frozen at start
    logic [LEN_W-1:0]     r_len;
    logic [1:0]           r_mode;
    logic [CNT_WIDTH-1:0] r_count;
    logic [15:0]          r_gap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len   <= LEN_W'(1);
            r_mode  <= 2'd0;
            r_count <= '0;
            r_gap   <= 16'd0;
        end else if (r_state == S_IDLE && start) begin
            r_len   <= (cfg_payload_len == 16'd0) ? LEN_W'(1) : cfg_payload_len;
            r_mode  <= cfg_mode;
            r_count <= cfg_pkt_count;
            r_gap   <= cfg_gap;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hdr_valid <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= 8'd0;
            r_ip_id     <= 16'd0;
            r_pkts      <= '0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_k         <= 8'd0;
            r_gap_cnt   <= 16'd0;
            r_prbs      <= PRBS_SEED;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_hdr_valid <= w_hdr_valid;
            r_tvalid    <= w_tvalid;
            r_tlast     <= w_tlast;
            r_tdata     <= w_tdata;
            r_ip_id     <= w_ip_id;
            r_pkts      <= w_pkts;
            r_busy      <= w_busy;
            r_idx       <= w_idx;
            r_k         <= w_k;
            r_gap_cnt   <= w_gap_cnt;
            r_prbs      <= w_prbs;
            r_stop_pend <= w_stop_pend;
        end
    end

    // Next state, next outputs and next payload byte
    always_comb begin
        w_state     = r_state;
        w_hdr_valid = r_hdr_valid;
        w_tvalid    = r_tvalid;
        w_tlast     = r_tlast;
        w_tdata     = r_tdata;
        w_ip_id     = r_ip_id;
        w_pkts      = r_pkts;
        w_busy      = r_busy;
        w_idx       = r_idx;
        w_k         = r_k;
        w_gap_cnt   = r_gap_cnt;
        w_prbs      = r_prbs;
        w_stop_pend = r_stop_pend;
        w_load      = 1'b0;
        w_pat       = CONST_BYTE;
        w_pkts_inc  = CNT_WIDTH'(r_pkts + CNT_WIDTH'(1));
        // x^7 + x^6 + 1
        w_prbs_step = {r_prbs[5:0], r_prbs[6] ^ r_prbs[5]};
`ifdef FYP_PKT_SEQ_EN
        w_pat_beat  = (r_idx >= LEN_W'(4));
`else
        w_pat_beat  = 1'b1;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state     = S_HDR;
                    w_hdr_valid = 1'b1;
                    w_busy      = 1'b1;
                    w_pkts      = '0;
                    w_prbs      = PRBS_SEED;
                    w_stop_pend = 1'b0;
                end
            end
            S_HDR: begin
                if (stop) begin
                    w_state     = S_IDLE;
                    w_hdr_valid = 1'b0;
                    w_busy      = 1'b0;
                end else if (bus.hdr_ready) begin
                    w_state     = S_PAYLOAD;
                    w_hdr_valid = 1'b0;
                    w_tvalid    = 1'b1;
                    w_idx       = '0;
                    w_k         = 8'd0;
                    w_tlast     = (r_len == LEN_W'(1));
                    w_load      = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (stop) begin
                    w_stop_pend = 1'b1;
                end
                if (bus.tready) begin
                    // PRBS advances only on pattern bytes, never on sequence bytes
                    if (w_pat_beat) begin
                        w_prbs = w_prbs_step;
                    end
                    if (r_tlast) begin
                        w_pkts   = w_pkts_inc;
                        w_ip_id  = 16'(r_ip_id + 16'd1);
                        w_tvalid = 1'b0;
                        w_tlast  = 1'b0;
                        w_idx    = '0;
                        if (r_stop_pend || stop ||
                            (r_count != '0 && w_pkts_inc == r_count)) begin
                            w_state     = S_IDLE;
                            w_busy      = 1'b0;
                            w_stop_pend = 1'b0;
                        end else if (r_gap == 16'd0) begin
                            w_state     = S_HDR;
                            w_hdr_valid = 1'b1;
                        end else begin
                            w_state   = S_GAP;
                            w_gap_cnt = 16'(r_gap - 16'd1);
                        end
                    end else begin
                        w_idx   = LEN_W'(r_idx + LEN_W'(1));
                        w_k     = w_pat_beat ? 8'(r_k + 8'd1) : r_k;
                        w_tlast = (w_idx == LEN_W'(r_len - LEN_W'(1)));
                        w_load  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end else if (r_gap_cnt == 16'd0) begin
                    w_state     = S_HDR;
                    w_hdr_valid = 1'b1;
                end else begin
                    w_gap_cnt = 16'(r_gap_cnt - 16'd1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Byte presented on the next beat, from next index / k / PRBS values
        case (r_mode)
            2'd1:    w_pat = w_k;
            2'd2:    w_pat = {1'b0, w_prbs};
            default: w_pat = CONST_BYTE;
        endcase
`ifdef FYP_PKT_SEQ_EN
        if (w_idx < LEN_W'(4)) begin
            case (w_idx[1:0])
                2'd0:    w_pat = 8'(32'(r_pkts) >> 24);
                2'd1:    w_pat = 8'(32'(r_pkts) >> 16);
                2'd2:    w_pat = 8'(32'(r_pkts) >> 8);
                default: w_pat = 8'(32'(r_pkts));
            endcase
        end
`endif
        if (w_load) begin
            w_tdata = w_pat;
        end
    end

    assign bus.hdr_valid = r_hdr_valid;
    assign bus.udp_src   = UDP_SRC;
    assign bus.udp_dst   = UDP_DST;
    assign bus.ip_dst    = IP_DST;
    assign bus.ip_id     = r_ip_id;
    assign bus.tdata     = r_tdata;
    assign bus.tvalid    = r_tvalid;
    assign bus.tlast     = r_tlast;
    assign bus.tuser     = 1'b0;
    assign pkts_sent     = r_pkts;
    assign busy          = r_busy;
endmodule

// File: tb/tb_fyp_udp_pkt_gen.sv
module tb_fyp_udp_pkt_gen;
    localparam int unsigned CNT_WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 stop;
    logic [15:0]          cfg_payload_len;
    logic [1:0]           cfg_mode;
    logic [CNT_WIDTH-1:0] cfg_pkt_count;
    logic [15:0]          cfg_gap;
    logic [CNT_WIDTH-1:0] pkts_sent;
    logic                 busy;

    fyp_udp_pkt_gen_if u_if ();

    fyp_udp_pkt_gen #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .cfg_payload_len (cfg_payload_len),
        .cfg_mode        (cfg_mode),
        .cfg_pkt_count   (cfg_pkt_count),
        .cfg_gap         (cfg_gap),
        .bus             (u_if),
        .pkts_sent       (pkts_sent),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int ip_base  = 0;

    logic [7:0] obs_data[$];
    logic       obs_last[$];
    int         obs_hdr_ip[$];
    int         obs_rise[$];
    int         obs_tlast_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];

    bit         prev_hv;
    bit         prev_hold;
    logic [7:0] hold_d;
    logic       hold_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready driver: 0 always ready, 1 random, 2 tready toggles, 3 hdr_ready low
    initial begin
        u_if.hdr_ready = 1'b1;
        u_if.tready    = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1: begin
                    u_if.hdr_ready = 1'($urandom_range(0, 1));
                    u_if.tready    = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    u_if.hdr_ready = 1'b1;
                    u_if.tready    = ~u_if.tready;
                end
                3: begin
                    u_if.hdr_ready = 1'b0;
                    u_if.tready    = 1'b1;
                end
                default: begin
                    u_if.hdr_ready = 1'b1;
                    u_if.tready    = 1'b1;
                end
            endcase
        end
    end

    // Bus monitor: records headers, beats, timing; checks hold while stalled
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_hold = 1'b0;
            prev_hv   = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_tvalid", 32'(u_if.tvalid), 32'd1);
                chk("hold_tdata", 32'(u_if.tdata), 32'(hold_d));
                chk("hold_tlast", 32'(u_if.tlast), 32'(hold_l));
            end
            prev_hold = u_if.tvalid && !u_if.tready;
            hold_d    = u_if.tdata;
            hold_l    = u_if.tlast;
            if (u_if.hdr_valid && !prev_hv) obs_rise.push_back(cyc);
            prev_hv = u_if.hdr_valid;
            if (u_if.hdr_valid && u_if.hdr_ready) begin
                obs_hdr_ip.push_back(int'(u_if.ip_id));
                chk("udp_src", 32'(u_if.udp_src), 32'h1111);
                chk("udp_dst", 32'(u_if.udp_dst), 32'h2222);
                chk("ip_dst", u_if.ip_dst, 32'hc0a80105);
            end
            if (u_if.tvalid && u_if.tready) begin
                obs_data.push_back(u_if.tdata);
                obs_last.push_back(u_if.tlast);
                chk("tuser", 32'(u_if.tuser), 32'd0);
                if (u_if.tlast) obs_tlast_cyc.push_back(cyc);
            end
        end
    end

    // Reference payload stream for npk packets of one burst
    task automatic build_exp(input int len, input int mode, input int npk);
        logic [6:0] p;
        int         plen;
        p    = 7'h7F;
        plen = (len == 0) ? 1 : len;
        exp_data.delete();
        exp_last.delete();
        for (int pk = 0; pk < npk; pk++) begin
            for (int j = 0; j < plen; j++) begin
                logic [7:0] b;
                int         k;
                bit         is_seq;
                is_seq = 1'b0;
                b      = 8'h11;
`ifdef FYP_PKT_SEQ_EN
                if (j < 4) begin
                    is_seq = 1'b1;
                    b = 8'((pk >> (24 - 8 * j)) & 255);
                end
                k = j - 4;
`else
                k = j;
`endif
                if (!is_seq) begin
                    if (mode == 1) b = 8'(k & 255);
                    else if (mode == 2) begin
                        b = {1'b0, p};
                        p = {p[5:0], p[6] ^ p[5]};
                    end
                end
                exp_data.push_back(b);
                exp_last.push_back(j == plen - 1);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        ip_base = 0;
    endtask

    task automatic do_start(input int len, input int mode, input int count, input int gap);
        obs_data.delete();
        obs_last.delete();
        obs_hdr_ip.delete();
        obs_rise.delete();
        obs_tlast_cyc.delete();
        @(posedge clk);
        #1;
        cfg_payload_len = 16'(len);
        cfg_mode        = 2'(mode);
        cfg_pkt_count   = CNT_WIDTH'(count);
        cfg_gap         = 16'(gap);
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_hdr_valid", 32'(u_if.hdr_valid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc, output int n);
        n = 0;
        while (busy && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_burst(input int npk, input int gap);
        chk("beat_count", 32'(obs_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            chk("tdata", 32'(obs_data[i]), 32'(exp_data[i]));
            chk("tlast", 32'(obs_last[i]), 32'(exp_last[i]));
        end
        chk("hdr_count", 32'(obs_hdr_ip.size()), 32'(npk));
        for (int p = 0; p < obs_hdr_ip.size() && p < npk; p++)
            chk("hdr_ip_id", 32'(obs_hdr_ip[p]), 32'((ip_base + p) & 16'hFFFF));
        for (int p = 1; p < npk && p < obs_rise.size() && p <= obs_tlast_cyc.size(); p++)
            chk("gap_cycles", 32'(obs_rise[p] - obs_tlast_cyc[p-1] - 1), 32'(gap));
        chk("pkts_sent", pkts_sent, CNT_WIDTH'(npk));
        ip_base = (ip_base + npk) & 16'hFFFF;
        chk("ip_id_after", 32'(u_if.ip_id), 32'(ip_base));
    endtask

    task automatic check_reset_vals();
        chk("rst_hdr_valid", 32'(u_if.hdr_valid), 32'd0);
        chk("rst_tvalid", 32'(u_if.tvalid), 32'd0);
        chk("rst_tlast", 32'(u_if.tlast), 32'd0);
        chk("rst_tuser", 32'(u_if.tuser), 32'd0);
        chk("rst_tdata", 32'(u_if.tdata), 32'd0);
        chk("rst_ip_id", 32'(u_if.ip_id), 32'd0);
        chk("rst_pkts_sent", pkts_sent, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int len, mode, count, gap;
        reset           = 1'b1;
        start           = 1'b0;
        stop            = 1'b0;
        cfg_payload_len = 16'd0;
        cfg_mode        = 2'd0;
        cfg_pkt_count   = '0;
        cfg_gap         = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;

        // Single 18-byte constant packet, back-to-back beats
        rdy_mode = 0;
        build_exp(18, 0, 1);
        do_start(18, 0, 1, 0);
        wait_idle(200, n);
        chk("burst1_cycles", 32'(n), 32'd19);
        check_burst(1, 0);

        // Three incrementing packets with a 5-cycle gap
        do_reset();
        build_exp(4, 1, 3);
        do_start(4, 1, 3, 5);
        wait_idle(400, n);
        check_burst(3, 5);

        // PRBS across two packets with tready toggling
        rdy_mode = 2;
        build_exp(10, 2, 2);
        do_start(10, 2, 2, 0);
        wait_idle(400, n);
        check_burst(2, 0);
        rdy_mode = 0;

        // Zero length, header stalled for 7 cycles
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        build_exp(0, 1, 1);
        do_start(0, 1, 1, 0);
        for (int i = 0; i < 7; i++) begin
            chk("stall_hdr_valid", 32'(u_if.hdr_valid), 32'd1);
            chk("stall_ip_id", 32'(u_if.ip_id), 32'(ip_base));
            chk("stall_tvalid", 32'(u_if.tvalid), 32'd0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        wait_idle(200, n);
        check_burst(1, 0);

        // Continuous mode, stop during beat 3 of packet 5
        build_exp(8, 1, 5);
        do_start(8, 1, 0, 1);
        n = 0;
        while (obs_data.size() < 35 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stop_wait_timeout", 32'(obs_data.size()), 32'd35);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_idle(200, n);
        check_burst(5, 1);

        // Stop during the gap suppresses the next header
        build_exp(2, 0, 1);
        do_start(2, 0, 0, 6);
        n = 0;
        while (obs_tlast_cyc.size() < 1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("gap_state_hdr_valid", 32'(u_if.hdr_valid), 32'd0);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("gap_stop_busy", 32'(busy), 32'd0);
        wait_idle(50, n);
        repeat (10) @(posedge clk);
        check_burst(1, 0);

        // Reset mid-payload, then a fresh short burst
        do_start(20, 1, 1, 0);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        reset   = 1'b0;
        ip_base = 0;
        build_exp(2, 1, 1);
        do_start(2, 1, 1, 0);
        wait_idle(100, n);
        check_burst(1, 0);

        // Two 6-byte incrementing packets (sequence field when enabled)
        build_exp(6, 1, 2);
        do_start(6, 1, 2, 0);
        wait_idle(200, n);
        check_burst(2, 0);

        // Random bursts with random back-pressure; cfg scrambled mid-burst
        rdy_mode = 1;
        for (int r = 0; r < 8; r++) begin
            len   = $urandom_range(0, 24);
            mode  = $urandom_range(0, 3);
            count = $urandom_range(1, 3);
            gap   = $urandom_range(0, 6);
            build_exp(len, mode, count);
            do_start(len, mode, count, gap);
            cfg_payload_len = 16'($urandom);
            cfg_mode        = 2'($urandom);
            cfg_pkt_count   = CNT_WIDTH'($urandom);
            cfg_gap         = 16'($urandom);
            wait_idle(3000, n);
            check_burst(count, gap);
        end
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fyp_udp_pkt_gen.md
Name: fyp_udp_pkt_gen

Overview:
Parametrised, runtime-configurable UDP payload/header source. It replaces the fixed 18-byte, fixed-pattern stimulus that feeds udp_checksum_gen. It generates bursts of N packets (or runs continuously) with programmable payload length, payload pattern and inter-packet gap. Each packet gets an incrementing IP identification. Outputs drive the udp_checksum_gen header (valid/ready) and 8-bit payload AXI-Stream inputs directly.

Parameters:
UDP_SRC, 16'h1111, UDP source port presented with every header
UDP_DST, 16'h2222, UDP destination port
IP_DST, 32'hc0a80105, IPv4 destination address
CONST_BYTE, 8'h11, payload byte for pattern mode 0
PRBS_SEED, 7'h7F, PRBS-7 seed loaded on start; must be non-zero
CNT_WIDTH, 32, width of packet-count config and sent counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; latches cfg_* and begins a burst when idle
stop  in  1  1-cycle pulse; ends the burst after the current packet
cfg_payload_len  in  16  payload bytes per packet; 0 is treated as 1
cfg_mode  in  2  0 constant, 1 incrementing, 2 PRBS-7, 3 same as 0
cfg_pkt_count  in  CNT_WIDTH  packets per burst; 0 = continuous
cfg_gap  in  16  idle cycles between the last payload beat and the next header
hdr_valid  out  1  header valid
hdr_ready  in  1  header ready from the checksum generator
udp_src  out  16  UDP_SRC
udp_dst  out  16  UDP_DST
ip_dst  out  32  IP_DST
ip_id  out  16  IP identification for the current packet
tdata  out  8  payload byte
tvalid  out  1  payload valid
tready  in  1  payload ready
tlast  out  1  final payload byte
tuser  out  1  always 0
pkts_sent  out  CNT_WIDTH  packets completed since the last start
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, highest priority, also mid-packet) returns the block to IDLE and sets: hdr_valid=0, tvalid=0, tlast=0, tuser=0, tdata=0, ip_id=0, pkts_sent=0, busy=0.
- States and transitions:
  - IDLE: start latches cfg_* into shadow registers, clears pkts_sent, loads the PRBS register with PRBS_SEED, then goes to HDR. start outside IDLE is ignored.
  - HDR: hdr_valid=1, with all header outputs stable. On hdr_valid&&hdr_ready, go to PAYLOAD next cycle; hdr_valid drops in that same cycle. There is no combinational path from ready to valid.
  - PAYLOAD: tvalid=1. A beat transfers on tvalid&&tready. The byte counter runs 0..len-1. tlast=1 only while the counter is len-1. tdata/tlast hold while tready=0.
  - On the tlast transfer: pkts_sent+1, ip_id+1 (wraps 16'hFFFF to 0). Then:
    - go to IDLE if a stop is pending, or if cfg_pkt_count!=0 and pkts_sent(new)==cfg_pkt_count;
    - otherwise go to GAP, or straight to HDR if cfg_gap==0.
  - GAP: wait exactly cfg_gap cycles with hdr_valid=0 and tvalid=0, then go to HDR.
- stop: a pulse in HDR or GAP returns to IDLE next cycle without emitting a header. A pulse in PAYLOAD sets a pending flag; the packet always completes; no truncated packets. A pulse in IDLE is ignored.
- Payload pattern (byte index k within the packet):
  - mode 0/3: CONST_BYTE.
  - mode 1: k[7:0]; restarts at 0 every packet, wraps 255 to 0.
  - mode 2: PRBS-7, polynomial x^7+x^6+1. tdata = {1'b0, prbs}. The register advances once per accepted beat and is NOT reset between packets within a burst.
- Latency: start to hdr_valid = 1 cycle. Header handshake to first tvalid = 1 cycle. Payload gives back-to-back beats when tready=1.
- cfg_* changes during a burst have no effect until the next start.
- busy falls on the cycle IDLE is entered.

Optional Feature:
FYP_PKT_SEQ_EN
- Defined: payload bytes 0..3 are replaced by pkts_sent (pre-increment value, low 32 bits, big-endian, byte 0 = MSB), and pattern index k for the remaining bytes restarts at 0 from byte 4. For len<4, only the first len sequence bytes are sent. The PRBS register does not advance on sequence bytes.
- Undefined: no sequence field; the pattern starts at byte 0.

Test Plan:
- len=18, mode=0, count=1, gap=0, tready/hdr_ready=1 -> one header; 18 beats of 8'h11; tlast on beat 18; pkts_sent=1; ip_id=1; busy low after last beat.
- len=4, mode=1, count=3, gap=5 -> three packets, each 00,01,02,03; exactly 5 idle cycles between tlast and the next hdr_valid; ip_id 0,1,2 on headers.
- mode=2, len=10, count=2 -> first bytes from seed 7F follow the PRBS-7 sequence; packet 2 continues the sequence (not reseeded); tready toggling 1/0 holds tdata stable.
- count=0, stop pulsed at payload beat 3 of packet 5, len=8 -> packet 5 completes all 8 bytes; no 6th header; pkts_sent=5; IDLE.
- len=0, hdr_ready held 0 for 7 cycles -> hdr_valid held 7 cycles with stable fields; then a single beat with tlast=1.
- reset asserted mid-payload, then start (len=2, mode=1) -> all outputs at reset values next cycle; the new burst sends 00,01; ip_id restarts at 0. With FYP_PKT_SEQ_EN, len=6, count=2 -> packet 2 payload 00 00 00 01 00 01.
